l2_bridge_outstanding_tracker: RTL and testbench



---
 rtl/l2_bridge_outstanding_tracker.sv | 118 +++++++++++
 tb/tb_l2_bridge_outstanding_tracker.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/l2_bridge_outstanding_tracker.sv
// l2_bridge_outstanding_tracker
//   Forwards the arbiter's merged request stream to the bridge slave. It
//   records {ID, aux} of every granted request in an in-order FIFO, and
//   re-attaches that tag to the slave's untagged in-order responses. The
//   FIFO depth (MAX_OUTSTANDING) caps the number of in-flight transactions.
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   data_*_i (req side)          request from arbiter (req/add/wen/wdata/be/ID/aux)
//   data_gnt_o                   grant back to arbiter
//   data_*_o (req side)          request to slave (req/add/wen/wdata/be)
//   data_gnt_i                   grant from slave
//   data_r_valid_i/rdata_i       in-order response from slave
//   data_r_valid_o/ID_o/aux_o/rdata_o  registered tagged response
//   outstanding_o                FIFO occupancy (registered)
//   err_underflow_o              sticky: response seen with empty FIFO
module l2_bridge_outstanding_tracker #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int BE_WIDTH        = DATA_WIDTH/8,
  parameter int ID_WIDTH        = 16,
  parameter int AUX_WIDTH       = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   data_req_i,
  input  logic [ADDR_WIDTH-1:0]                  data_add_i,
  input  logic                                   data_wen_i,
  input  logic [DATA_WIDTH-1:0]                  data_wdata_i,
  input  logic [BE_WIDTH-1:0]                    data_be_i,
  input  logic [ID_WIDTH-1:0]                    data_ID_i,
  input  logic [AUX_WIDTH-1:0]                   data_aux_i,
  output logic                                   data_gnt_o,
  output logic                                   data_req_o,
  output logic [ADDR_WIDTH-1:0]                  data_add_o,
  output logic                                   data_wen_o,
  output logic [DATA_WIDTH-1:0]                  data_wdata_o,
  output logic [BE_WIDTH-1:0]                    data_be_o,
  input  logic                                   data_gnt_i,
  input  logic                                   data_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                  data_r_rdata_i,
  output logic                                   data_r_valid_o,
  output logic [ID_WIDTH-1:0]                    data_r_ID_o,
  output logic [AUX_WIDTH-1:0]                   data_r_aux_o,
  output logic [DATA_WIDTH-1:0]                  data_r_rdata_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
  output logic                                   err_underflow_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING+1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [CW-1:0]        count;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [ID_WIDTH-1:0]  id_mem  [MAX_OUTSTANDING];
  logic [AUX_WIDTH-1:0] aux_mem [MAX_OUTSTANDING];
  logic                 full, empty, push, pop;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING-1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count == CW'(MAX_OUTSTANDING));
  assign empty = (count == '0);

  // Full blocks on the registered count only: a same-cycle pop does not
  // free the slot until the next cycle, keeping the request path short.
  assign data_req_o   = data_req_i & ~full;
  assign data_gnt_o   = data_gnt_i & ~full;
  assign data_add_o   = data_add_i;
  assign data_wen_o   = data_wen_i;
  assign data_wdata_o = data_wdata_i;
  assign data_be_o    = data_be_i;

  assign push = data_req_o & data_gnt_i;
  // A slave response can never be for a request granted in the same cycle,
  // so pop only looks at already-stored entries.
  assign pop  = data_r_valid_i & ~empty;

  assign outstanding_o = count;

  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr]  <= data_ID_i;
      aux_mem[wr_ptr] <= data_aux_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count           <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      data_r_valid_o  <= 1'b0;
      data_r_ID_o     <= '0;
      data_r_aux_o    <= '0;
      data_r_rdata_o  <= '0;
      err_underflow_o <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      data_r_valid_o <= pop;
      if (pop) begin
        data_r_ID_o    <= id_mem[rd_ptr];
        data_r_aux_o   <= aux_mem[rd_ptr];
        data_r_rdata_o <= data_r_rdata_i;
      end
      if (data_r_valid_i && empty) err_underflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l2_bridge_outstanding_tracker.sv
// Bench for l2_bridge_outstanding_tracker: two instances (depth 4 and depth 3)
// share one stimulus stream and are checked against a queue-based model.
module tb_l2_bridge_outstanding_tracker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_i, wen_i, gnt_i, rv_i;
  logic [31:0] add_i, wdata_i, aux_i, rdata_i;
  logic [3:0]  be_i;
  logic [15:0] id_i;

  logic [1:0]  gnt_o, req_o, wen_o, rv_o, err_o;
  logic [31:0] add_o [2];
  logic [31:0] wdata_o [2];
  logic [3:0]  be_o [2];
  logic [15:0] rid_o [2];
  logic [31:0] raux_o [2];
  logic [31:0] rdata_o [2];
  logic [2:0]  outs0;
  logic [1:0]  outs1;

  l2_bridge_outstanding_tracker #(.MAX_OUTSTANDING(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .data_req_i(req_i), .data_add_i(add_i), .data_wen_i(wen_i), .data_wdata_i(wdata_i),
    .data_be_i(be_i), .data_ID_i(id_i), .data_aux_i(aux_i), .data_gnt_o(gnt_o[0]),
    .data_req_o(req_o[0]), .data_add_o(add_o[0]), .data_wen_o(wen_o[0]),
    .data_wdata_o(wdata_o[0]), .data_be_o(be_o[0]), .data_gnt_i(gnt_i),
    .data_r_valid_i(rv_i), .data_r_rdata_i(rdata_i), .data_r_valid_o(rv_o[0]),
    .data_r_ID_o(rid_o[0]), .data_r_aux_o(raux_o[0]), .data_r_rdata_o(rdata_o[0]),
    .outstanding_o(outs0), .err_underflow_o(err_o[0])
  );

  l2_bridge_outstanding_tracker #(.MAX_OUTSTANDING(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .data_req_i(req_i), .data_add_i(add_i), .data_wen_i(wen_i), .data_wdata_i(wdata_i),
    .data_be_i(be_i), .data_ID_i(id_i), .data_aux_i(aux_i), .data_gnt_o(gnt_o[1]),
    .data_req_o(req_o[1]), .data_add_o(add_o[1]), .data_wen_o(wen_o[1]),
    .data_wdata_o(wdata_o[1]), .data_be_o(be_o[1]), .data_gnt_i(gnt_i),
    .data_r_valid_i(rv_i), .data_r_rdata_i(rdata_i), .data_r_valid_o(rv_o[1]),
    .data_r_ID_o(rid_o[1]), .data_r_aux_o(raux_o[1]), .data_r_rdata_o(rdata_o[1]),
    .outstanding_o(outs1), .err_underflow_o(err_o[1])
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: one in-order list of outstanding transactions, each tagged with
  // the instance it belongs to.
  typedef struct { int k; logic [15:0] id; logic [31:0] aux; } ent_t;
  ent_t mq[$];
  int   mx [2] = '{4, 3};
  logic        e_rv [2], e_err [2];
  logic [15:0] e_id [2];
  logic [31:0] e_aux [2], e_rd [2];

  function automatic int cnt(input int k);
    int c = 0;
    foreach (mq[i]) if (mq[i].k == k) c++;
    return c;
  endfunction

  function automatic int first_of(input int k);
    foreach (mq[i]) if (mq[i].k == k) return i;
    return -1;
  endfunction

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < 2; k++) begin
      e_rv[k] = 0; e_err[k] = 0; e_id[k] = '0; e_aux[k] = '0; e_rd[k] = '0;
    end
  endtask

  task automatic set_in(input logic r, input logic g, input logic v);
    req_i = r; gnt_i = g; rv_i = v;
    id_i = 16'h1 << $urandom_range(0, 15);
    aux_i = $urandom; add_i = $urandom; wdata_i = $urandom; rdata_i = $urandom;
    wen_i = 1'($urandom); be_i = 4'($urandom);
  endtask

  // One clock: check combinational path, advance, check registered outputs.
  task automatic step();
    logic push [2], pop [2];
    int   c [2];
    #1;
    for (int k = 0; k < 2; k++) begin
      c[k] = cnt(k);
      chk($sformatf("req_o%0d", k), req_o[k], req_i && (c[k] != mx[k]));
      chk($sformatf("gnt_o%0d", k), gnt_o[k], gnt_i && (c[k] != mx[k]));
      chk($sformatf("pass%0d", k), {add_o[k], wdata_o[k]}, {add_i, wdata_i});
      chk($sformatf("wenbe%0d", k), {wen_o[k], be_o[k]}, {wen_i, be_i});
      push[k] = req_i && gnt_i && (c[k] != mx[k]);
      pop[k]  = rv_i && (c[k] > 0);
    end
    @(posedge clk); #1;
    if (rst) model_reset();
    else begin
      for (int k = 0; k < 2; k++) begin
        e_rv[k] = pop[k];
        if (pop[k]) begin
          int i = first_of(k);
          e_id[k] = mq[i].id; e_aux[k] = mq[i].aux; e_rd[k] = rdata_i;
          mq.delete(i);
        end
        if (rv_i && c[k] == 0) e_err[k] = 1;
      end
      for (int k = 0; k < 2; k++) if (push[k]) mq.push_back('{k, id_i, aux_i});
    end
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("r_valid%0d", k), rv_o[k], e_rv[k]);
      chk($sformatf("r_id%0d", k), rid_o[k], e_id[k]);
      chk($sformatf("r_aux%0d", k), raux_o[k], e_aux[k]);
      chk($sformatf("r_rdata%0d", k), rdata_o[k], e_rd[k]);
      chk($sformatf("err%0d", k), err_o[k], e_err[k]);
    end
    chk("outs0", outs0, cnt(0));
    chk("outs1", outs1, cnt(1));
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    set_in(0, 0, 0);
    step(); step();
    rst = 1'b0;

    // Single read, tag re-attached two cycles later.
    set_in(1, 1, 0); id_i = 16'h0004; aux_i = 32'hA5; step();
    chk("single_outs_1", outs0, 1);
    set_in(0, 0, 0); step();
    set_in(0, 0, 1); rdata_i = 32'hDEADBEEF; step();
    chk("single_id", rid_o[0], 16'h0004);
    chk("single_rdata", rdata_o[0], 32'hDEADBEEF);
    chk("single_outs_0", outs0, 0);
    set_in(0, 0, 0); step();

    // Fill beyond both depths, then full + same-cycle pop, then accept.
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 0); id_i = 16'h1 << i; step();
    end
    chk("fill_outs4", outs0, 4);
    chk("fill_outs3", outs1, 3);
    set_in(1, 1, 1); step();
    chk("fullpop_outs", outs0, 3);
    set_in(1, 1, 0); step();
    chk("fullpop_refill", outs0, 4);
    for (int i = 0; i < 6; i++) begin
      set_in(0, 0, cnt(1) > 0); step();
    end

    // Random legal traffic: responses only when the shallower instance
    // (which never holds more than the deeper one) has entries.
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
             (cnt(1) > 0) && ($urandom_range(0, 9) < 6));
      step();
    end

    // Reset with transactions outstanding.
    set_in(1, 1, 0); step(); step();
    rst = 1'b1; set_in(0, 0, 0); step();
    rst = 1'b0;
    chk("rst_outs", outs0, 0);

    // Underflow is sticky across later legal traffic.
    set_in(0, 0, 1); step();
    chk("uflow", err_o[0], 1'b1);
    for (int i = 0; i < 30; i++) begin
      set_in($urandom_range(0, 1), 1, (cnt(1) > 0) && $urandom_range(0, 1));
      step();
    end
    chk("uflow_sticky", err_o[1], 1'b1);

    // Reset clears the error; a fresh pair tags correctly.
    rst = 1'b1; set_in(0, 0, 0); step();
    rst = 1'b0;
    set_in(1, 1, 0); id_i = 16'h0080; aux_i = 32'h1234_5678; step();
    set_in(0, 0, 1); step();
    chk("post_rst_id", rid_o[1], 16'h0080);
    chk("post_rst_err", err_o[0], 1'b0);
    set_in(0, 0, 0); step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
